// File: rtl/tvip_axi_burst_address_generator_pkg.sv
// Shared AXI types and helpers used by the burst address generator and strobe logic.
package tvip_axi_burst_address_generator_pkg;

  typedef logic [7:0] tvip_axi_burst_length;
  typedef logic [2:0] tvip_axi_burst_size;

  typedef enum logic [1:0] {
    BURST_FIXED    = 2'b00,
    BURST_INCR     = 2'b01,
    BURST_WRAP     = 2'b10,
    BURST_RESERVED = 2'b11
  } tvip_axi_burst_type;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } tvip_axi_gen_state;

  localparam int BOUNDARY_4KB = 4096;

  function automatic logic [7:0] burst_byte_count(input tvip_axi_burst_size size);
    return 8'd1 << size;
  endfunction

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
  function automatic logic wrap_length_legal(input tvip_axi_burst_length len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/tvip_axi_burst_address_generator_strobe.sv
// Combinational byte-lane strobe for one beat, derived from the beat address offset and size.
module tvip_axi_strobe_generator
  import tvip_axi_burst_address_generator_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int OFFSET_W   = ((DATA_WIDTH / 8) > 1) ? $clog2(DATA_WIDTH / 8) : 1
) (
  input  logic [OFFSET_W-1:0]     offset,
  input  logic [2:0]              size,
  output logic [DATA_WIDTH/8-1:0] strobe
);

  localparam int LANE_W = DATA_WIDTH / 8;

  int bytes;
  int lo;
  int hi;

  // Lanes run from the raw offset to the end of the size-aligned container;
  // an oversize beat simply lights every lane.
  always_comb begin
    strobe = '0;
    bytes  = int'(burst_byte_count(size));
    lo     = int'(offset) % LANE_W;
    hi     = ((int'(offset) & ~(bytes - 1)) % LANE_W) + bytes - 1;
    for (int i = 0; i < LANE_W; i++) begin
      if ((bytes > LANE_W) || ((i >= lo) && (i <= hi))) begin
        strobe[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tvip_axi_burst_address_generator.sv
// Expands one AXI AW/AR request into per-beat address/strobe/index/last descriptors,
// flagging illegal bursts while still producing every beat.
module tvip_axi_burst_address_generator
  import tvip_axi_burst_address_generator_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 64,
  parameter int DATA_WIDTH    = 64,
  parameter int ID_WIDTH      = 8
) (
  input  logic                     aclk,
  input  logic                     areset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ID_WIDTH-1:0]      req_id,
  input  logic [ADDRESS_WIDTH-1:0] req_address,
  input  logic [7:0]               req_burst_length,
  input  logic [2:0]               req_burst_size,
  input  logic [1:0]               req_burst_type,
  output logic                     beat_valid,
  input  logic                     beat_ready,
  output logic [ID_WIDTH-1:0]      beat_id,
  output logic [ADDRESS_WIDTH-1:0] beat_address,
  output logic [DATA_WIDTH/8-1:0]  beat_strobe,
  output logic [7:0]               beat_index,
  output logic                     beat_last,
  output logic                     beat_error,
  output logic                     busy
);

  localparam int LANE_W   = DATA_WIDTH / 8;
  localparam int OFFSET_W = (LANE_W > 1) ? $clog2(LANE_W) : 1;

  tvip_axi_gen_state          state_q;
  tvip_axi_gen_state          state_d;
  tvip_axi_burst_length       len_q;
  tvip_axi_burst_size         size_q;
  tvip_axi_burst_type         type_q;
  tvip_axi_burst_type         req_type;
  logic [ADDRESS_WIDTH-1:0]   wrap_lower_q;
  logic [ADDRESS_WIDTH-1:0]   wrap_upper_q;

  logic                       last_hs;
  logic                       accept;
  logic                       advance;
  logic                       req_error;
  logic [ADDRESS_WIDTH-1:0]   req_bytes;
  logic [ADDRESS_WIDTH-1:0]   req_span;
  logic [ADDRESS_WIDTH-1:0]   req_lower;
  logic [11:0]                req_page_offset;
  int                         req_bytes_i;
  logic [ADDRESS_WIDTH-1:0]   cur_bytes;
  logic [ADDRESS_WIDTH-1:0]   wrap_sum;
  logic [ADDRESS_WIDTH-1:0]   next_address;
  logic [ADDRESS_WIDTH-1:0]   load_address;
  logic [2:0]                 load_size;
  logic [DATA_WIDTH/8-1:0]    load_strobe;

  assign busy       = (state_q == ST_ACTIVE);
  assign beat_valid = busy;
  assign last_hs    = beat_valid && beat_ready && beat_last;
  assign req_ready  = (state_q == ST_IDLE) || last_hs;
  assign accept     = req_valid && req_ready;
  assign advance    = beat_valid && beat_ready && !beat_last;
  assign req_type   = tvip_axi_burst_type'(req_burst_type);

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_ACTIVE;
      ST_ACTIVE: if (last_hs && !accept) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Request decode and legality checks, evaluated on the incoming request.
  always_comb begin
    req_bytes       = ADDRESS_WIDTH'(burst_byte_count(req_burst_size));
    req_bytes_i     = int'(burst_byte_count(req_burst_size));
    req_span        = req_bytes * ADDRESS_WIDTH'({1'b0, req_burst_length} + 9'd1);
    req_lower       = req_address & ~(req_span - 1'b1);
    req_page_offset = req_address[11:0] & ~(12'(burst_byte_count(req_burst_size)) - 12'd1);
    req_error       = (req_bytes_i > LANE_W);
    case (req_type)
      BURST_FIXED:    if (req_burst_length > 8'd15) req_error = 1'b1;
      BURST_INCR: begin
        if (int'(req_page_offset) + (int'(req_burst_length) + 1) * req_bytes_i > BOUNDARY_4KB)
          req_error = 1'b1;
      end
      BURST_WRAP: begin
        if (!wrap_length_legal(req_burst_length) || ((req_address & (req_bytes - 1'b1)) != '0))
          req_error = 1'b1;
      end
      default:        req_error = 1'b1;
    endcase
  end

  // Next-beat address; reserved type is sequenced like INCR.
  always_comb begin
    cur_bytes = ADDRESS_WIDTH'(burst_byte_count(size_q));
    wrap_sum  = beat_address + cur_bytes;
    case (type_q)
      BURST_FIXED: next_address = beat_address;
      BURST_WRAP:  next_address = (wrap_sum == wrap_upper_q) ? wrap_lower_q : wrap_sum;
      default:     next_address = (beat_address & ~(cur_bytes - 1'b1)) + cur_bytes;
    endcase
    load_address = accept ? req_address : next_address;
    load_size    = accept ? req_burst_size : size_q;
  end

  tvip_axi_strobe_generator #(
    .DATA_WIDTH (DATA_WIDTH),
    .OFFSET_W   (OFFSET_W)
  ) u_strobe (
    .offset (load_address[OFFSET_W-1:0]),
    .size   (load_size),
    .strobe (load_strobe)
  );

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      beat_id      <= '0;
      beat_address <= '0;
      beat_strobe  <= '0;
      beat_index   <= '0;
      beat_last    <= 1'b0;
      beat_error   <= 1'b0;
      len_q        <= '0;
      size_q       <= '0;
      type_q       <= BURST_FIXED;
      wrap_lower_q <= '0;
      wrap_upper_q <= '0;
    end else if (accept) begin
      beat_id      <= req_id;
      beat_address <= req_address;
      beat_strobe  <= load_strobe;
      beat_index   <= 8'd0;
      beat_last    <= (req_burst_length == 8'd0);
      beat_error   <= req_error;
      len_q        <= req_burst_length;
      size_q       <= req_burst_size;
      type_q       <= req_type;
      wrap_lower_q <= req_lower;
      wrap_upper_q <= req_lower + req_span;
    end else if (advance) begin
      beat_address <= next_address;
      beat_strobe  <= load_strobe;
      beat_index   <= beat_index + 8'd1;
      beat_last    <= ((beat_index + 8'd1) == len_q);
    end
  end

endmodule

// File: doc/tvip_axi_burst_address_generator.md
# tvip_axi_burst_address_generator

Converts one AXI address-channel request (AW or AR) into a stream of per-beat transfer descriptors: beat address, byte-lane strobe, beat index and last flag. Handles FIXED, INCR and WRAP bursts for any burst size up to the data-bus width. Checks protocol legality on acceptance. Sits between the address-channel monitor/driver and the data-channel logic in both master and slave agents, and replaces per-beat address arithmetic currently spread across components.

## Interface
- ADDRESS_WIDTH, default 64: address width in bits; all address arithmetic is modulo 2^ADDRESS_WIDTH.
- DATA_WIDTH, default 64: data-bus width in bits; power of two, 8..1024. Strobe width is DATA_WIDTH/8.
- ID_WIDTH, default 8: transaction ID width.

Ports:
- aclk  in  1  clock. Single clock domain.
- areset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request ready.
- req_id  in  ID_WIDTH  transaction ID.
- req_address  in  ADDRESS_WIDTH  start address; may be unaligned.
- req_burst_length  in  8  encoded AxLEN (beats − 1).
- req_burst_size  in  3  encoded AxSIZE (bytes = 1 << size).
- req_burst_type  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- beat_valid  out  1  beat descriptor valid.
- beat_ready  in  1  beat descriptor accepted.
- beat_id  out  ID_WIDTH  ID of the current burst.
- beat_address  out  ADDRESS_WIDTH  address of this beat.
- beat_strobe  out  DATA_WIDTH/8  active byte lanes of this beat.
- beat_index  out  8  beat number, starting at 0.
- beat_last  out  1  final beat of the burst.
- beat_error  out  1  the burst failed a legality check; constant for the whole burst.
- busy  out  1  a burst is in progress.

## Operation
- Two-state FSM: IDLE and ACTIVE.
- IDLE, req_valid=1: the request is captured, the FSM moves to ACTIVE, and beat 0 is presented.
- ACTIVE, beat handshake on a non-last beat: advance to the next beat.
- ACTIVE, beat handshake on the last beat: return to IDLE, or capture a new request if one is handshaken in the same cycle.
- Request is accepted when req_valid && req_ready. req_ready = IDLE || (beat_valid && beat_ready && beat_last).
- bytes = 1 << size. aligned = address & ~(bytes − 1). lane offset = address mod (DATA_WIDTH/8).
- Beat 0 address is req_address unchanged.
- FIXED: every beat uses req_address and the beat-0 strobe.
- INCR: beat n (n ≥ 1) address = aligned + n·bytes.
- WRAP: span = bytes × beats; lower boundary = address & ~(span − 1). Next address = current + bytes; if it equals lower boundary + span, it becomes the lower boundary.
- Strobe: set lanes from (beat_address mod lanes) through ((aligned_beat_address mod lanes) + bytes − 1). All other lanes are 0.
- beat_error is set at acceptance if any check fails:
  - bytes > DATA_WIDTH/8;
  - type is 11;
  - WRAP with beats not in {2, 4, 8, 16}, or with an unaligned address;
  - INCR where aligned[11:0] + beats·bytes > 4096;
  - FIXED with beats > 16.
- An erroneous burst still produces every beat. A reserved type (11) is sequenced as INCR. For an oversize burst size, the strobe is all lanes.

## Timing
- Reset values: req_ready=1; beat_valid=0; busy=0; beat_last=0; beat_error=0; beat_address, beat_strobe, beat_index and beat_id are 0.
- All beat_* outputs are registered. Latency from request handshake to beat_valid is 1 cycle.
- Back-to-back bursts have no bubble: beat 0 of the next burst follows the last beat of the previous one in the next cycle.
- When beat_valid=1 and beat_ready=0, all beat_* outputs hold stable.
- beat_last is 1 exactly when beat_index equals the captured req_burst_length. A single-beat burst asserts beat_last on beat 0.
- busy = ACTIVE.
- Reset asserted mid-burst: all outputs go to their reset values asynchronously, the in-progress burst is discarded, and no beats resume after reset is released.

## Structure
- Add to the shared AXI types package:
  - a burst-byte-count function (size → bytes);
  - a WRAP-length legality function;
  - a 4 KB boundary constant.
- Existing burst size, type and length typedefs are reused.
- One sub-module, tvip_axi_strobe_generator: combinational; computes the strobe from address, size and DATA_WIDTH.
- The FSM, address sequencing and legality checks stay in the top module.

## Test plan
All scenarios use DATA_WIDTH=32 unless noted.
- INCR, len=3, size=2 (4 B), address 0x1002 → addresses 0x1002, 0x1004, 0x1008, 0x100C; strobes 1100, 1111, 1111, 1111; beat_last on index 3; beat_error=0.
- WRAP, len=3, size=2, address 0x0038 → addresses 0x38, 0x3C, 0x30, 0x34; all strobes 1111.
- FIXED, len=2, size=1 (2 B), address 0x0006 → three beats, each at 0x0006 with strobe 1100.
- Backpressure: beat_ready held low for 3 cycles mid-burst → outputs stable. Second request offered during the last beat → accepted in that cycle, and its beat 0 appears the next cycle.
- Errors:
  - size=3 on the 32-bit bus → beat_error=1 with all-lane strobe;
  - WRAP with len=2 → beat_error=1;
  - INCR at 0x0FFC, len=1, size=2 → beat_error=1, with both beats still generated.
- Reset pulse at beat 1 of a 4-beat burst → all outputs at reset values. After release, req_ready=1 and no stray beats appear.
